// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin front end for a shared saturating up/down counter.
// Grants one requester at a time, pre-checks the command for overflow/underflow,
// drives the counter for a single cycle, then verifies the result and responds.
module counter_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       req_dir,
  input  logic [N_REQ*WIDTH-1:0] req_amount,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic                   busy,
  output logic                   fault,
  output logic                   cnt_reset,
  output logic                   cnt_increment,
  output logic                   cnt_decrement,
  output logic [WIDTH-1:0]       cnt_amount,
  input  logic [WIDTH-1:0]       cnt_count
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCheck,
    StResp
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  amt_q, amt_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic              ok_q, ok_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              fault_q, fault_d;

  logic              win_valid;
  logic [IdxW-1:0]   win_idx;
  logic              win_dir;
  logic [WIDTH-1:0]  win_amt;
  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    diff;
  logic              reject;
  logic [N_REQ-1:0]  idx_oh;

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_q) + i) % N_REQ;
      if (!win_valid && req[IdxW'(cand)]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  // Winner's command and the pre-check; the carry/borrow bit flags out-of-range results.
  always_comb begin
    win_dir = req_dir[win_idx];
    win_amt = req_amount[win_idx*WIDTH +: WIDTH];
    sum     = {1'b0, cnt_count} + {1'b0, win_amt};
    diff    = {1'b0, cnt_count} - {1'b0, win_amt};
    reject  = win_dir ? sum[WIDTH] : diff[WIDTH];
  end

  // Next-state logic for the sequencer and its latched command.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    dir_d      = dir_q;
    amt_d      = amt_q;
    expected_d = expected_q;
    ok_d       = ok_q;
    grant_d    = '0;
    fault_d    = fault_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          grant_d    = N_REQ'(1) << win_idx;
          idx_d      = win_idx;
          last_d     = win_idx;
          dir_d      = win_dir;
          amt_d      = win_amt;
          expected_d = win_dir ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
          if (reject) begin
            ok_d    = 1'b0;
            state_d = StResp;
          end else if (win_amt == '0) begin
            // Nothing to apply; answer immediately without touching the counter.
            ok_d    = 1'b1;
            state_d = StResp;
          end else begin
            ok_d    = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StCheck;
      end
      StCheck: begin
        // Counter did not land where the pre-check predicted; still report done.
        if (cnt_count != expected_q) begin
          fault_d = 1'b1;
        end
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_q     <= IdxW'(N_REQ - 1);
      idx_q      <= '0;
      dir_q      <= 1'b0;
      amt_q      <= '0;
      expected_q <= '0;
      ok_q       <= 1'b0;
      grant_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      dir_q      <= dir_d;
      amt_q      <= amt_d;
      expected_q <= expected_d;
      ok_q       <= ok_d;
      grant_q    <= grant_d;
      fault_q    <= fault_d;
    end
  end

  // Output decode; counter command is only non-zero while issuing.
  always_comb begin
    idx_oh        = N_REQ'(1) << idx_q;
    grant         = grant_q;
    busy          = (state_q != StIdle);
    fault         = fault_q;
    cnt_reset     = ~reset;
    cnt_increment = 1'b0;
    cnt_decrement = 1'b0;
    cnt_amount    = '0;
    done          = '0;
    err           = '0;
    if (state_q == StIssue) begin
      cnt_increment = dir_q;
      cnt_decrement = ~dir_q;
      cnt_amount    = amt_q;
    end
    if (state_q == StResp) begin
      if (ok_q) begin
        done = idx_oh;
      end else begin
        err = idx_oh;
      end
    end
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter with a behavioural saturating counter attached.
module tb_counter_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_dir = '0;
  logic [N*W-1:0] req_amount = '0;
  logic [N-1:0]   grant, done, err;
  logic           busy, fault, cnt_reset, cnt_increment, cnt_decrement;
  logic [W-1:0]   cnt_amount;
  logic [W-1:0]   m_count;
  logic           drop_en = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_dir      (req_dir),
    .req_amount   (req_amount),
    .grant        (grant),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .fault        (fault),
    .cnt_reset    (cnt_reset),
    .cnt_increment(cnt_increment),
    .cnt_decrement(cnt_decrement),
    .cnt_amount   (cnt_amount),
    .cnt_count    (m_count)
  );

  // Saturating counter; drop_en makes it ignore a command to provoke a fault.
  always @(posedge clk) begin
    if (cnt_reset) begin
      m_count <= '0;
    end else if ((cnt_increment || cnt_decrement) && !drop_en) begin
      if (cnt_increment) begin
        m_count <= (({1'b0, m_count} + {1'b0, cnt_amount}) > 9'd255) ? 8'd255
                                                                      : m_count + cnt_amount;
      end else begin
        m_count <= (cnt_amount > m_count) ? 8'd0 : m_count - cnt_amount;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a one-cycle command from requester k; returns in the grant cycle.
  task automatic issue(input int k, input bit d, input int a);
    req              = 4'(1 << k);
    req_dir          = d ? 4'hF : 4'h0;
    req_amount       = '0;
    req_amount[k*W +: W] = 8'(a);
    tick();
    req = '0;
  endtask

  // From the grant cycle of a normal command: expect done at cycle 3, idle at 4.
  task automatic finish_ok(input string tag, input int k);
    tick();
    tick();
    chk({tag, "_done"}, done, 4'(1 << k));
    chk({tag, "_err"}, err, 0);
    tick();
  endtask

  logic [N-1:0] rr_exp [5];

  initial begin
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held for three cycles
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_busy_fault", {busy, fault}, 0);
    chk("rst_cmd", {cnt_increment, cnt_decrement, cnt_amount}, 0);
    chk("rst_cnt_reset", cnt_reset, 1);
    reset = 1'b1;

    // First command: inc 5 from requester 0
    issue(0, 1'b1, 5);
    chk("c1_grant", grant, 4'b0001);
    chk("c1_inc", {cnt_increment, cnt_decrement}, 2'b10);
    chk("c1_amt", cnt_amount, 5);
    chk("c1_busy", busy, 1);
    chk("c1_cnt_reset", cnt_reset, 0);
    tick();
    chk("c2_cmd_off", {cnt_increment, cnt_decrement, cnt_amount}, 0);
    chk("c2_count", m_count, 5);
    tick();
    chk("c3_done", done, 4'b0001);
    chk("c3_err", err, 0);
    tick();
    chk("c4_idle", {busy, done, grant}, 0);

    // Round-robin from a fresh reset with all four requesting inc 1
    reset = 1'b0;
    repeat (2) tick();
    reset      = 1'b1;
    req        = 4'hF;
    req_dir    = 4'hF;
    req_amount = {4{8'd1}};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_grant", grant, rr_exp[i]);
      tick();
      tick();
      chk("rr_done", done, rr_exp[i]);
      tick();
    end
    req = '0;
    chk("rr_count", m_count, 5);

    // Overflow boundary
    issue(1, 1'b1, 245);
    finish_ok("to250", 1);
    chk("to250_count", m_count, 250);
    issue(2, 1'b1, 5);
    finish_ok("to255", 2);
    chk("to255_count", m_count, 255);
    issue(3, 1'b1, 1);
    chk("ovf_grant", grant, 4'b1000);
    chk("ovf_err", err, 4'b1000);
    chk("ovf_done", done, 0);
    chk("ovf_inc", {cnt_increment, cnt_decrement}, 0);
    tick();
    chk("ovf_idle", busy, 0);
    chk("ovf_count", m_count, 255);

    // Underflow boundary and zero amount
    issue(0, 1'b0, 252);
    finish_ok("to3", 0);
    chk("to3_count", m_count, 3);
    issue(1, 1'b0, 3);
    finish_ok("to0", 1);
    chk("to0_count", m_count, 0);
    issue(2, 1'b0, 1);
    chk("udf_err", err, 4'b0100);
    chk("udf_done", done, 0);
    chk("udf_dec", cnt_decrement, 0);
    tick();
    issue(3, 1'b1, 0);
    chk("zero_done", done, 4'b1000);
    chk("zero_err", err, 0);
    chk("zero_cmd", {cnt_increment, cnt_decrement, cnt_amount}, 0);
    tick();
    chk("zero_idle", busy, 0);
    chk("zero_count", m_count, 0);
    chk("no_fault_yet", fault, 0);

    // Reset dropped in the CHECK cycle
    issue(1, 1'b1, 7);
    tick();
    chk("mid_check_count", m_count, 7);
    reset = 1'b0;
    tick();
    chk("mid_no_done", {done, err}, 0);
    chk("mid_idle", busy, 0);
    chk("mid_fault", fault, 0);
    chk("mid_count", m_count, 0);
    reset = 1'b1;
    tick();

    // Counter ignores one command: fault must appear after CHECK and stick
    drop_en = 1'b1;
    issue(0, 1'b1, 4);
    tick();
    drop_en = 1'b0;
    chk("flt_check_count", m_count, 0);
    chk("flt_check_fault", fault, 0);
    tick();
    chk("flt_set", fault, 1);
    chk("flt_done", done, 4'b0001);
    tick();
    chk("flt_hold", fault, 1);
    issue(1, 1'b1, 1);
    finish_ok("flt_next", 1);
    chk("flt_sticky", fault, 1);
    chk("flt_next_count", m_count, 1);
    reset = 1'b0;
    tick();
    chk("flt_clear", fault, 0);
    reset = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
